tawas_regfile: RTL and testbench
================================

Name: tawas_regfile

Overview:
- Dual-slice (two hardware threads) register file: 2 banks x 8 registers x 32 bits.
- Serves the Tawas arithmetic unit: combinational A/B reads for the current SLICE; registered write-back of the AU result into the opposite bank, since the result arrives one cycle after issue.
- Second write port for load-store writeback, plus a per-register pending scoreboard. It drives a stall when a current-slice read touches a register whose load has not yet returned.

Parameters:
- REG_RESET_VAL, 32'd0, value loaded into every register on reset.
- WB_BYPASS, 1, 1 = same-cycle LS writeback data is forwarded to matching reads and suppresses stall; 0 = no forwarding.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- SLICE  in  1  current issuing slice; toggles every cycle upstream
- AU_RA_SEL  in  3  A read select, bank SLICE
- AU_RA  out  32  A read data, combinational
- AU_RB_SEL  in  3  B read select, bank SLICE
- AU_RB  out  32  B read data, combinational
- AU_RC_VLD  in  1  AU write-back valid; targets bank !SLICE
- AU_RC_SEL  in  3  AU write register
- AU_RC  in  32  AU write data
- LS_RD_SEL  in  3  LS read select (store data/address), bank SLICE
- LS_RD  out  32  LS read data, combinational
- LS_LD_ISSUE  in  1  load issued for bank SLICE; marks LS_LD_SEL pending
- LS_LD_SEL  in  3  load destination register
- LS_WB_VLD  in  1  load data return valid
- LS_WB_SLICE  in  1  bank of returning load
- LS_WB_SEL  in  3  register of returning load
- LS_WB_DATA  in  32  returned data
- RF_STALL  out  1  current-slice read hits a pending register
- RF_PEND  out  16  scoreboard; [7:0] bank 0, [15:8] bank 1
- RF_ERR  out  1  sticky protocol error

Behaviour:
- Reset is asynchronous and active-high on RST; clock is CLK. During reset:
  - all 16 registers <= REG_RESET_VAL;
  - RF_PEND <= 0;
  - RF_ERR <= 0.
  - RF_STALL therefore reads 0, and read outputs show REG_RESET_VAL.
  - Reset mid-load discards the pending state; a later LS_WB to that register still writes normally.
- Reads: AU_RA, AU_RB and LS_RD are regs[SLICE][sel], combinational, zero latency.
- Read forwarding (WB_BYPASS=1): if LS_WB_VLD, LS_WB_SLICE==SLICE and LS_WB_SEL==sel, the read returns LS_WB_DATA.
- No AU forwarding is needed. AU writes always target !SLICE, and that bank is next read in the following cycle, after the write has committed.
- Writes commit on the CLK rising edge.
  - AU: if AU_RC_VLD, regs[!SLICE][AU_RC_SEL] <= AU_RC.
  - LS: if LS_WB_VLD, regs[LS_WB_SLICE][LS_WB_SEL] <= LS_WB_DATA.
  - Same bank and same register in the same cycle: LS writeback wins, AU write is dropped, RF_ERR set.
  - Different register, or different bank: both writes commit.
- Scoreboard, per bank and register:
  - set on LS_LD_ISSUE for (SLICE, LS_LD_SEL);
  - cleared on LS_WB_VLD for (LS_WB_SLICE, LS_WB_SEL);
  - same-cycle set and clear on the same entry: set wins, because the new load is outstanding.
- Scoreboard errors (set RF_ERR):
  - LS_LD_ISSUE to an already pending entry; the entry stays pending;
  - LS_WB_VLD to a non-pending entry; data is still written;
  - AU_RC_VLD to a pending entry of bank !SLICE; data is still written.
- RF_STALL is combinational: OR over the three read selects of pend[SLICE][sel].
  - A read matched by a same-cycle LS writeback does not stall when WB_BYPASS=1.
  - Reads are always evaluated; the issuer qualifies them.
- RF_ERR stays set until RST.
- No handshake backpressure: every write and issue is accepted in the cycle presented.

Test Plan:
1. Reset, then SLICE=0, AU_RA_SEL=3 -> AU_RA=0, RF_STALL=0, RF_PEND=0, RF_ERR=0.
2. SLICE=1 with AU_RC_VLD=1, SEL=5, data 0x12345678 -> next cycle SLICE=0, AU_RB_SEL=5 -> AU_RB=0x12345678. Bank 1 r5 is unchanged (still 0).
3. SLICE=0, LS_LD_ISSUE, SEL=2 -> RF_PEND[2]=1. Two cycles later, SLICE=0, AU_RA_SEL=2 -> RF_STALL=1. SLICE=1, AU_RA_SEL=2 -> RF_STALL=0.
4. Pending bank0 r2. SLICE=0, AU_RA_SEL=2, same cycle LS_WB_VLD, SLICE 0, SEL 2, data 0xCAFEF00D -> AU_RA=0xCAFEF00D, RF_STALL=0, RF_PEND[2] clears next edge. Repeat with WB_BYPASS=0 -> RF_STALL=1, AU_RA holds the old value.
5. SLICE=0 with bank1 r4 pending; AU_RC_VLD and LS_WB_VLD both target bank1 r4 (AU 0x1, LS 0x2) -> r4=0x2, RF_PEND[12]=0, RF_ERR=1 and remains 1.
6. RST asserted while RF_PEND=0x0101 -> RF_PEND=0 and registers = REG_RESET_VAL immediately (asynchronous). A later LS_WB to bank0 r0 writes data and sets RF_ERR.

Source files
------------

// File: rtl/tawas_regfile.sv
// Two-bank register file for the Tawas AU. Reads come combinationally from the
// issuing slice's bank. AU results are written to the other bank. A scoreboard tracks loads that are still outstanding.
module tawas_regfile #(
   parameter logic [31:0] REG_RESET_VAL = 32'd0,
   parameter int          WB_BYPASS     = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SLICE,
   input  logic [2:0]  AU_RA_SEL,
   output logic [31:0] AU_RA,
   input  logic [2:0]  AU_RB_SEL,
   output logic [31:0] AU_RB,
   input  logic        AU_RC_VLD,
   input  logic [2:0]  AU_RC_SEL,
   input  logic [31:0] AU_RC,
   input  logic [2:0]  LS_RD_SEL,
   output logic [31:0] LS_RD,
   input  logic        LS_LD_ISSUE,
   input  logic [2:0]  LS_LD_SEL,
   input  logic        LS_WB_VLD,
   input  logic        LS_WB_SLICE,
   input  logic [2:0]  LS_WB_SEL,
   input  logic [31:0] LS_WB_DATA,
   output logic        RF_STALL,
   output logic [15:0] RF_PEND,
   output logic        RF_ERR
);

   localparam logic bypassEn = (WB_BYPASS != 0);

   logic [31:0] regs_q [2][8];
   logic [15:0] pend_q, pend_d;
   logic        err_q, err_d;

   logic       auBank;
   logic [3:0] auIdx, wbIdx, issueIdx;
   logic       wbSameBank, raHit, rbHit, ldHit, auCollide, auWrEn;

   assign auBank   = ~SLICE;
   assign auIdx    = {auBank, AU_RC_SEL};
   assign wbIdx    = {LS_WB_SLICE, LS_WB_SEL};
   assign issueIdx = {SLICE, LS_LD_SEL};

   // A returning load into the current bank forwards its data to any matching read.
   assign wbSameBank = bypassEn && LS_WB_VLD && (LS_WB_SLICE == SLICE);
   assign raHit      = wbSameBank && (LS_WB_SEL == AU_RA_SEL);
   assign rbHit      = wbSameBank && (LS_WB_SEL == AU_RB_SEL);
   assign ldHit      = wbSameBank && (LS_WB_SEL == LS_RD_SEL);

   assign AU_RA = raHit ? LS_WB_DATA : regs_q[SLICE][AU_RA_SEL];
   assign AU_RB = rbHit ? LS_WB_DATA : regs_q[SLICE][AU_RB_SEL];
   assign LS_RD = ldHit ? LS_WB_DATA : regs_q[SLICE][LS_RD_SEL];

   assign RF_STALL = (pend_q[{SLICE, AU_RA_SEL}] && !raHit)
                   | (pend_q[{SLICE, AU_RB_SEL}] && !rbHit)
                   | (pend_q[{SLICE, LS_RD_SEL}] && !ldHit);

   assign RF_PEND = pend_q;
   assign RF_ERR  = err_q;

   // When the AU and a load target the same register, the load data is kept.
   assign auCollide = AU_RC_VLD && LS_WB_VLD && (wbIdx == auIdx);
   assign auWrEn    = AU_RC_VLD && !auCollide;

   // Scoreboard update. A new load issued in the cycle its predecessor returns is
   // legal and leaves the entry pending.
   always_comb begin
      pend_d = pend_q;
      err_d  = err_q;
      if (LS_WB_VLD) begin
         if (!pend_q[wbIdx]) err_d = 1'b1;
         pend_d[wbIdx] = 1'b0;
      end
      if (LS_LD_ISSUE) begin
         if (pend_q[issueIdx] && !(LS_WB_VLD && (wbIdx == issueIdx))) err_d = 1'b1;
         pend_d[issueIdx] = 1'b1;
      end
      if (AU_RC_VLD && pend_q[auIdx]) err_d = 1'b1;
      if (auCollide) err_d = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 8; r++) begin
               regs_q[b][r] <= REG_RESET_VAL;
            end
         end
      end else begin
         if (auWrEn) regs_q[auBank][AU_RC_SEL] <= AU_RC;
         if (LS_WB_VLD) regs_q[LS_WB_SLICE][LS_WB_SEL] <= LS_WB_DATA;
      end
   end

endmodule

// File: tb/tb_tawas_regfile.sv
// Bench for tawas_regfile: directed scenarios and random traffic compared against
// an array-based reference model, with and without writeback forwarding.
module tb_tawas_regfile;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        slice;
   logic [2:0]  raSel, rbSel, rcSel, rdSel, ldSel, wbSel;
   logic        rcVld, ldIssue, wbVld, wbSlice;
   logic [31:0] rcData, wbData;

   logic [31:0] auRa, auRb, lsRd, auRaNb, auRbNb, lsRdNb;
   logic        stall, stallNb, err, errNb;
   logic [15:0] pend, pendNb;

   int checks = 0;
   int failures = 0;

   logic [31:0] mRegs [2][8];
   bit          mPend [2][8];
   bit          mErr;

   always #5 clock = ~clock;

   tawas_regfile #(.REG_RESET_VAL(32'd0), .WB_BYPASS(1)) dut (
      .CLK(clock), .RST(reset), .SLICE(slice),
      .AU_RA_SEL(raSel), .AU_RA(auRa), .AU_RB_SEL(rbSel), .AU_RB(auRb),
      .AU_RC_VLD(rcVld), .AU_RC_SEL(rcSel), .AU_RC(rcData),
      .LS_RD_SEL(rdSel), .LS_RD(lsRd), .LS_LD_ISSUE(ldIssue), .LS_LD_SEL(ldSel),
      .LS_WB_VLD(wbVld), .LS_WB_SLICE(wbSlice), .LS_WB_SEL(wbSel), .LS_WB_DATA(wbData),
      .RF_STALL(stall), .RF_PEND(pend), .RF_ERR(err));

   tawas_regfile #(.REG_RESET_VAL(32'd0), .WB_BYPASS(0)) dutNb (
      .CLK(clock), .RST(reset), .SLICE(slice),
      .AU_RA_SEL(raSel), .AU_RA(auRaNb), .AU_RB_SEL(rbSel), .AU_RB(auRbNb),
      .AU_RC_VLD(rcVld), .AU_RC_SEL(rcSel), .AU_RC(rcData),
      .LS_RD_SEL(rdSel), .LS_RD(lsRdNb), .LS_LD_ISSUE(ldIssue), .LS_LD_SEL(ldSel),
      .LS_WB_VLD(wbVld), .LS_WB_SLICE(wbSlice), .LS_WB_SEL(wbSel), .LS_WB_DATA(wbData),
      .RF_STALL(stallNb), .RF_PEND(pendNb), .RF_ERR(errNb));

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // A read returns forwarded load data when forwarding is on and the load hits it.
   function automatic logic [31:0] mRead(input logic [2:0] sel, input bit byp);
      if (byp && wbVld && wbSlice == slice && wbSel == sel) return wbData;
      return mRegs[slice][sel];
   endfunction

   function automatic logic mStall(input bit byp);
      logic [2:0] sels [3];
      logic s = 1'b0;
      sels[0] = raSel; sels[1] = rbSel; sels[2] = rdSel;
      foreach (sels[k]) begin
         if (mPend[slice][sels[k]] && !(byp && wbVld && wbSlice == slice && wbSel == sels[k]))
            s = 1'b1;
      end
      return s;
   endfunction

   function automatic logic [15:0] mPendVec();
      logic [15:0] v = '0;
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 8; r++)
            v[b*8+r] = mPend[b][r];
      return v;
   endfunction

   task automatic modelReset();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 8; r++) begin
            mRegs[b][r] = 32'd0;
            mPend[b][r] = 1'b0;
         end
      mErr = 1'b0;
   endtask

   // Applies one rising edge worth of writes, scoreboard changes and error rules.
   task automatic modelUpdate();
      logic auB = ~slice;
      bit   collide = rcVld && wbVld && wbSlice == auB && wbSel == rcSel;
      if (ldIssue && mPend[slice][ldSel] && !(wbVld && wbSlice == slice && wbSel == ldSel)) mErr = 1'b1;
      if (wbVld && !mPend[wbSlice][wbSel]) mErr = 1'b1;
      if (rcVld && mPend[auB][rcSel]) mErr = 1'b1;
      if (collide) mErr = 1'b1;
      if (rcVld && !collide) mRegs[auB][rcSel] = rcData;
      if (wbVld) begin
         mRegs[wbSlice][wbSel] = wbData;
         mPend[wbSlice][wbSel] = 1'b0;
      end
      if (ldIssue) mPend[slice][ldSel] = 1'b1;
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_ra"}, auRa, mRead(raSel, 1));
      checkOutput({tag, "_rb"}, auRb, mRead(rbSel, 1));
      checkOutput({tag, "_ld"}, lsRd, mRead(rdSel, 1));
      checkOutput({tag, "_stall"}, {31'd0, stall}, {31'd0, mStall(1)});
      checkOutput({tag, "_pend"}, {16'd0, pend}, {16'd0, mPendVec()});
      checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, mErr});
      checkOutput({tag, "_raNb"}, auRaNb, mRead(raSel, 0));
      checkOutput({tag, "_rbNb"}, auRbNb, mRead(rbSel, 0));
      checkOutput({tag, "_ldNb"}, lsRdNb, mRead(rdSel, 0));
      checkOutput({tag, "_stallNb"}, {31'd0, stallNb}, {31'd0, mStall(0)});
      checkOutput({tag, "_pendNb"}, {16'd0, pendNb}, {16'd0, mPendVec()});
      checkOutput({tag, "_errNb"}, {31'd0, errNb}, {31'd0, mErr});
   endtask

   task automatic applyStimulus(input logic s, input logic [2:0] ra, input logic [2:0] rb,
                                input logic [2:0] rd);
      slice = s; raSel = ra; rbSel = rb; rdSel = rd;
      rcVld = 1'b0; rcSel = 3'd0; rcData = 32'd0;
      ldIssue = 1'b0; ldSel = 3'd0;
      wbVld = 1'b0; wbSlice = 1'b0; wbSel = 3'd0; wbData = 32'd0;
   endtask

   task automatic settle(input string tag);
      #2;
      checkAll(tag);
   endtask

   task automatic advance();
      @(posedge clock);
      modelUpdate();
      #1;
   endtask

   // Asynchronous reset pulse; outputs are checked while the clock is quiet.
   task automatic doReset(input string tag);
      reset = 1'b1;
      #1;
      modelReset();
      checkAll(tag);
      reset = 1'b0;
      advance();
   endtask

   initial begin
      applyStimulus(1'b0, 3'd3, 3'd0, 3'd0);
      #1;
      doReset("t1rst");

      // Reset state read-out
      applyStimulus(1'b0, 3'd3, 3'd0, 3'd0);
      settle("t1");
      checkOutput("t1_ra0", auRa, 32'd0);
      checkOutput("t1_pend0", {16'd0, pend}, 32'd0);
      advance();

      // AU write lands in the opposite bank
      applyStimulus(1'b1, 3'd0, 3'd5, 3'd0);
      rcVld = 1'b1; rcSel = 3'd5; rcData = 32'h12345678;
      settle("t2a");
      advance();
      applyStimulus(1'b0, 3'd0, 3'd5, 3'd0);
      settle("t2b");
      checkOutput("t2_rb_bank0", auRb, 32'h12345678);
      advance();
      applyStimulus(1'b1, 3'd0, 3'd5, 3'd0);
      settle("t2c");
      checkOutput("t2_rb_bank1", auRb, 32'd0);
      advance();

      // Load issue and stall on the pending register
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0);
      ldIssue = 1'b1; ldSel = 3'd2;
      settle("t3a");
      advance();
      applyStimulus(1'b1, 3'd0, 3'd0, 3'd0);
      settle("t3b");
      checkOutput("t3_pend2", {31'd0, pend[2]}, 32'd1);
      advance();
      applyStimulus(1'b0, 3'd2, 3'd0, 3'd0);
      settle("t3c");
      checkOutput("t3_stall", {31'd0, stall}, 32'd1);
      advance();
      applyStimulus(1'b1, 3'd2, 3'd0, 3'd0);
      settle("t3d");
      checkOutput("t3_nostall", {31'd0, stall}, 32'd0);
      advance();

      // Same-cycle writeback forwarding versus no forwarding
      applyStimulus(1'b0, 3'd2, 3'd1, 3'd1);
      wbVld = 1'b1; wbSlice = 1'b0; wbSel = 3'd2; wbData = 32'hCAFEF00D;
      settle("t4a");
      checkOutput("t4_fwd_ra", auRa, 32'hCAFEF00D);
      checkOutput("t4_fwd_stall", {31'd0, stall}, 32'd0);
      checkOutput("t4_nb_stall", {31'd0, stallNb}, 32'd1);
      checkOutput("t4_nb_ra", auRaNb, 32'd0);
      advance();
      applyStimulus(1'b1, 3'd0, 3'd0, 3'd0);
      settle("t4b");
      checkOutput("t4_pend_clr", {16'd0, pend}, 32'd0);
      checkOutput("t4_noerr", {31'd0, err}, 32'd0);
      advance();

      // AU and LS collide on pending bank1 r4
      applyStimulus(1'b1, 3'd0, 3'd0, 3'd0);
      ldIssue = 1'b1; ldSel = 3'd4;
      settle("t5a");
      advance();
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0);
      rcVld = 1'b1; rcSel = 3'd4; rcData = 32'h1;
      wbVld = 1'b1; wbSlice = 1'b1; wbSel = 3'd4; wbData = 32'h2;
      settle("t5b");
      advance();
      applyStimulus(1'b1, 3'd4, 3'd0, 3'd0);
      settle("t5c");
      checkOutput("t5_r4", auRa, 32'h2);
      checkOutput("t5_pend12", {31'd0, pend[12]}, 32'd0);
      checkOutput("t5_err", {31'd0, err}, 32'd1);
      advance();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(~slice, 3'd0, 3'd0, 3'd0);
         settle("t5d");
         checkOutput("t5_err_sticky", {31'd0, err}, 32'd1);
         advance();
      end

      // Asynchronous reset while two loads are outstanding
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0);
      ldIssue = 1'b1; ldSel = 3'd0;
      settle("t6a");
      advance();
      applyStimulus(1'b1, 3'd0, 3'd0, 3'd0);
      ldIssue = 1'b1; ldSel = 3'd0;
      settle("t6b");
      advance();
      applyStimulus(1'b0, 3'd5, 3'd0, 3'd0);
      settle("t6c");
      checkOutput("t6_pend_pre", {16'd0, pend}, 32'h0101);
      checkOutput("t6_ra_pre", auRa, 32'h12345678);
      reset = 1'b1;
      #1;
      checkOutput("t6_pend_async", {16'd0, pend}, 32'd0);
      checkOutput("t6_ra_async", auRa, 32'd0);
      checkOutput("t6_err_async", {31'd0, err}, 32'd0);
      modelReset();
      checkAll("t6rst");
      reset = 1'b0;
      advance();
      applyStimulus(1'b1, 3'd0, 3'd0, 3'd0);
      wbVld = 1'b1; wbSlice = 1'b0; wbSel = 3'd0; wbData = 32'hA5A5A5A5;
      settle("t6d");
      advance();
      applyStimulus(1'b0, 3'd0, 3'd0, 3'd0);
      settle("t6e");
      checkOutput("t6_r0", auRa, 32'hA5A5A5A5);
      checkOutput("t6_err", {31'd0, err}, 32'd1);
      advance();

      // Random traffic in several reset-separated blocks
      for (int blk = 0; blk < 4; blk++) begin
         applyStimulus(1'b0, 3'd0, 3'd0, 3'd0);
         doReset("rndrst");
         for (int i = 0; i < 100; i++) begin
            applyStimulus(~slice, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)));
            rcVld   = ($urandom_range(0, 1) == 0);
            rcSel   = 3'($urandom_range(0, 7));
            rcData  = $urandom;
            ldIssue = ($urandom_range(0, 3) == 0);
            ldSel   = 3'($urandom_range(0, 7));
            wbVld   = ($urandom_range(0, 2) == 0);
            wbSlice = 1'($urandom_range(0, 1));
            wbSel   = 3'($urandom_range(0, 7));
            wbData  = $urandom;
            settle("rnd");
            advance();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
